// File: rtl/fetch_queue.sv
// Instruction fetch queue: credit-limited memory request issue, in-order PC tagging
// of responses, a Depth-entry {pc, data} FIFO, and redirect flush of stale responses.
module fetch_queue_chk #(
   parameter int CW    = 3,
   parameter int Depth = 4
) (
   input logic          clk_i,
   input logic          rst_ni,
   input logic          push_i,
   input logic          pop_i,
   input logic [CW-1:0] count_i
);
   localparam logic [CW-1:0] Full = CW'(Depth);

   a_no_overflow: assert property (@(posedge clk_i) disable iff (!rst_ni)
      !(push_i && !pop_i && (count_i == Full)));
endmodule

module fetch_queue #(
   parameter int              Xlen           = 32,
   parameter int              Ilen           = 32,
   parameter int              Depth          = 4,
   parameter int              MaxOutstanding = 2,
   parameter logic [Xlen-1:0] ResetPc        = '0
) (
   input  logic                       clk_i,
   input  logic                       rst_ni,
   input  logic                       redirect_i,
   input  logic [Xlen-1:0]            redirect_pc_i,
   input  logic                       mem_ready_i,
   output logic                       mem_valid_o,
   output logic [Xlen-1:0]            mem_addr_o,
   input  logic [Xlen-1:0]            mem_rdata_i,
   input  logic                       mem_rvalid_i,
   input  logic                       inst_ready_i,
   output logic                       inst_valid_o,
   output logic [Xlen-1:0]            inst_pc_o,
   output logic [Ilen-1:0]            inst_data_o,
   output logic [$clog2(Depth+1)-1:0] count_o
);
   localparam int PW = $clog2(Depth);
   localparam int CW = $clog2(Depth + 1);
   localparam int OW = $clog2(MaxOutstanding + 1);
   localparam int TW = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1;
   localparam logic [OW-1:0] MaxOut  = OW'(MaxOutstanding);
   localparam logic [CW:0]   DepthC  = (CW+1)'(Depth);
   localparam logic [TW-1:0] TagLast = TW'(MaxOutstanding - 1);

   logic [Xlen-1:0] fetch_pc_q, fetch_pc_d;
   logic [OW-1:0]   outstanding_q, outstanding_d;
   logic [OW-1:0]   discard_q, discard_d;
   logic [CW-1:0]   count_q, count_d;
   logic [PW-1:0]   rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
   logic [TW-1:0]   tag_rd_q, tag_rd_d, tag_wr_q, tag_wr_d;
   logic [Xlen-1:0] tag_mem_q  [MaxOutstanding];
   logic [Xlen-1:0] pc_mem_q   [Depth];
   logic [Ilen-1:0] data_mem_q [Depth];
   logic            accept_s, push_s, pop_s;
   logic [CW:0]     credit_s;
   logic            unused_pc_bits;

   assign unused_pc_bits = ^redirect_pc_i[1:0];
   assign mem_addr_o     = fetch_pc_q;
   assign inst_valid_o   = (count_q != '0);
   assign inst_pc_o      = pc_mem_q[rd_ptr_q];
   assign inst_data_o    = data_mem_q[rd_ptr_q];
   assign count_o        = count_q;

   // Stale in-flight requests still hold credits, so the sum bounds FIFO occupancy.
   always_comb begin
      credit_s    = (CW+1)'(outstanding_q) + (CW+1)'(count_q);
      mem_valid_o = rst_ni && !redirect_i && (outstanding_q < MaxOut) && (credit_s < DepthC);
      accept_s    = mem_valid_o && mem_ready_i;
      push_s      = mem_rvalid_i && !redirect_i && (discard_q == '0);
      pop_s       = inst_valid_o && inst_ready_i && !redirect_i;
   end

   // Next-state logic for fetch PC, request bookkeeping, tag queue and FIFO pointers.
   always_comb begin
      fetch_pc_d    = fetch_pc_q;
      outstanding_d = outstanding_q;
      discard_d     = discard_q;
      tag_wr_d      = tag_wr_q;
      tag_rd_d      = tag_rd_q;
      count_d       = count_q;
      rd_ptr_d      = rd_ptr_q;
      wr_ptr_d      = wr_ptr_q;

      if (redirect_i) begin
         fetch_pc_d = {redirect_pc_i[Xlen-1:2], 2'b00};
      end else if (accept_s) begin
         fetch_pc_d = fetch_pc_q + Xlen'(32'd4);
      end else begin
         fetch_pc_d = fetch_pc_q;
      end

      case ({accept_s, mem_rvalid_i})
         2'b10:   outstanding_d = outstanding_q + OW'(1'b1);
         2'b01:   outstanding_d = outstanding_q - OW'(1'b1);
         default: outstanding_d = outstanding_q;
      endcase

      // Every request still in flight becomes stale, including those already marked.
      if (redirect_i) begin
         discard_d = outstanding_q - OW'(mem_rvalid_i);
      end else if (mem_rvalid_i && (discard_q != '0)) begin
         discard_d = discard_q - OW'(1'b1);
      end else begin
         discard_d = discard_q;
      end

      if (accept_s) begin
         tag_wr_d = (tag_wr_q == TagLast) ? '0 : tag_wr_q + TW'(1'b1);
      end else begin
         tag_wr_d = tag_wr_q;
      end

      if (redirect_i) begin
         tag_rd_d = tag_wr_q;
      end else if (push_s) begin
         tag_rd_d = (tag_rd_q == TagLast) ? '0 : tag_rd_q + TW'(1'b1);
      end else begin
         tag_rd_d = tag_rd_q;
      end

      if (redirect_i) begin
         count_d  = '0;
         rd_ptr_d = wr_ptr_q;
         wr_ptr_d = wr_ptr_q;
      end else begin
         count_d  = count_q + CW'(push_s) - CW'(pop_s);
         rd_ptr_d = rd_ptr_q + PW'(pop_s);
         wr_ptr_d = wr_ptr_q + PW'(push_s);
      end
   end

   // Control state registers.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         fetch_pc_q    <= ResetPc;
         outstanding_q <= '0;
         discard_q     <= '0;
         count_q       <= '0;
         rd_ptr_q      <= '0;
         wr_ptr_q      <= '0;
         tag_rd_q      <= '0;
         tag_wr_q      <= '0;
      end else begin
         fetch_pc_q    <= fetch_pc_d;
         outstanding_q <= outstanding_d;
         discard_q     <= discard_d;
         count_q       <= count_d;
         rd_ptr_q      <= rd_ptr_d;
         wr_ptr_q      <= wr_ptr_d;
         tag_rd_q      <= tag_rd_d;
         tag_wr_q      <= tag_wr_d;
      end
   end

   // Tag and FIFO storage; contents are only meaningful behind the pointers.
   always_ff @(posedge clk_i) begin
      if (accept_s) begin
         tag_mem_q[tag_wr_q] <= fetch_pc_q;
      end
      if (push_s) begin
         pc_mem_q[wr_ptr_q]   <= tag_mem_q[tag_rd_q];
         data_mem_q[wr_ptr_q] <= mem_rdata_i[Ilen-1:0];
      end
   end

   fetch_queue_chk #(.CW(CW), .Depth(Depth)) u_chk (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .push_i  (push_s),
      .pop_i   (pop_s),
      .count_i (count_q)
   );
endmodule

// File: tb/tb_fetch_queue.sv
// Scoreboard bench for fetch_queue: a behavioural memory tracks stale requests itself
// and queues the expected {pc, data} for every response that should reach the FIFO.
module tb_fetch_queue;
   localparam logic [31:0] ResetPc = 32'h0000_0000;

   logic        clk_i = 1'b0;
   logic        rst_ni = 1'b0;
   logic        redirect_i = 1'b0;
   logic [31:0] redirect_pc_i = 32'd0;
   logic        mem_ready_i = 1'b0;
   logic        mem_valid_o;
   logic [31:0] mem_addr_o;
   logic [31:0] mem_rdata_i = 32'd0;
   logic        mem_rvalid_i = 1'b0;
   logic        inst_ready_i = 1'b0;
   logic        inst_valid_o;
   logic [31:0] inst_pc_o;
   logic [31:0] inst_data_o;
   logic [2:0]  count_o;

   always #5 clk_i = ~clk_i;

   fetch_queue #(.Xlen(32), .Ilen(32), .Depth(4), .MaxOutstanding(2), .ResetPc(ResetPc)) dut (
      .clk_i(clk_i), .rst_ni(rst_ni), .redirect_i(redirect_i), .redirect_pc_i(redirect_pc_i),
      .mem_ready_i(mem_ready_i), .mem_valid_o(mem_valid_o), .mem_addr_o(mem_addr_o),
      .mem_rdata_i(mem_rdata_i), .mem_rvalid_i(mem_rvalid_i), .inst_ready_i(inst_ready_i),
      .inst_valid_o(inst_valid_o), .inst_pc_o(inst_pc_o), .inst_data_o(inst_data_o),
      .count_o(count_o)
   );

   int          n_checks = 0;
   int          n_pass = 0;
   int          cyc = 0;
   bit          resp_hold = 1'b0;
   logic [31:0] exp_pc = ResetPc;
   logic [31:0] pend_addr[$];
   logic [31:0] pend_exp[$];
   int          pend_due[$];
   bit          pend_stale[$];
   logic [31:0] sb_pc[$];
   logic [31:0] sb_data[$];
   logic [31:0] pop_log[$];
   logic        s_inst_valid, s_mem_valid;
   logic [2:0]  s_count;
   logic [31:0] s_addr;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
   endfunction

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
   endtask

   // One clock cycle: called at a falling edge, drives, samples, then waits for the next one.
   task automatic step();
      mem_rvalid_i = 1'b0;
      mem_rdata_i  = 32'd0;
      if (pend_addr.size() > 0 && !resp_hold && pend_due[0] <= cyc) begin
         mem_rvalid_i = 1'b1;
         mem_rdata_i  = mem_word(pend_addr[0]);
         if (!pend_stale[0] && !redirect_i) begin
            sb_pc.push_back(pend_exp[0]);
            sb_data.push_back(mem_word(pend_exp[0]));
         end
         void'(pend_addr.pop_front());
         void'(pend_exp.pop_front());
         void'(pend_due.pop_front());
         void'(pend_stale.pop_front());
      end
      if (redirect_i) begin
         foreach (pend_stale[i]) pend_stale[i] = 1'b1;
         sb_pc.delete();
         sb_data.delete();
         exp_pc = {redirect_pc_i[31:2], 2'b00};
      end
      #1;
      s_inst_valid = inst_valid_o;
      s_mem_valid  = mem_valid_o;
      s_count      = count_o;
      s_addr       = mem_addr_o;
      if (mem_valid_o && mem_ready_i) begin
         chk("req_addr", mem_addr_o, exp_pc);
         pend_addr.push_back(mem_addr_o);
         pend_exp.push_back(exp_pc);
         pend_due.push_back(cyc + 1);
         pend_stale.push_back(1'b0);
         exp_pc = exp_pc + 32'd4;
      end
      if (inst_valid_o && inst_ready_i && !redirect_i) begin
         pop_log.push_back(inst_pc_o);
         if (sb_pc.size() == 0) begin
            chk("unexpected_inst", 32'(sb_pc.size()), 32'd1);
         end else begin
            chk("inst_pc", inst_pc_o, sb_pc[0]);
            chk("inst_data", inst_data_o, sb_data[0]);
            void'(sb_pc.pop_front());
            void'(sb_data.pop_front());
         end
      end
      @(negedge clk_i);
      cyc++;
   endtask

   task automatic do_reset();
      rst_ni = 1'b0;
      #1;
      chk("rst_inst_valid", 32'(inst_valid_o), 32'd0);
      chk("rst_mem_valid", 32'(mem_valid_o), 32'd0);
      chk("rst_count", 32'(count_o), 32'd0);
      pend_addr.delete(); pend_exp.delete(); pend_due.delete(); pend_stale.delete();
      sb_pc.delete(); sb_data.delete(); pop_log.delete();
      exp_pc = ResetPc;
      redirect_i = 1'b0;
      resp_hold = 1'b0;
      mem_rvalid_i = 1'b0;
      repeat (2) @(negedge clk_i);
      rst_ni = 1'b1;
      #1;
      chk("post_rst_mem_valid", 32'(mem_valid_o), 32'd1);
      chk("post_rst_addr", mem_addr_o, ResetPc);
   endtask

   task automatic wait_pops(input int n, input int budget);
      for (int k = 0; k < budget && pop_log.size() < n; k++) step();
      chk("pop_timeout", 32'(pop_log.size() >= n), 32'd1);
   endtask

   task automatic build_outstanding();
      resp_hold = 1'b1;
      for (int k = 0; k < 20 && pend_addr.size() < 2; k++) step();
      chk("build_outstanding", 32'(pend_addr.size()), 32'd2);
   endtask

   initial begin
      int          gaps;
      bit          seen;
      logic [31:0] exp_list [5];

      @(negedge clk_i);
      do_reset();

      // Streaming with an always-ready memory and consumer.
      mem_ready_i = 1'b1; inst_ready_i = 1'b1;
      gaps = 0; seen = 1'b0;
      for (int k = 0; k < 30; k++) begin
         step();
         if (s_inst_valid) seen = 1'b1;
         else if (seen) gaps++;
      end
      chk("stream_gaps", 32'(gaps), 32'd0);
      chk("stream_pops", 32'(pop_log.size()), 32'd28);
      chk("stream_first_pc", pop_log[0], 32'h0);

      // Backpressure: queue fills to Depth and requests stop.
      mem_ready_i = 1'b1; inst_ready_i = 1'b0;
      do_reset();
      repeat (10) step();
      chk("bp_count", 32'(s_count), 32'd4);
      chk("bp_mem_valid", 32'(s_mem_valid), 32'd0);
      inst_ready_i = 1'b1;
      wait_pops(5, 20);
      exp_list[0] = 32'h0; exp_list[1] = 32'h4; exp_list[2] = 32'h8;
      exp_list[3] = 32'hC; exp_list[4] = 32'h10;
      for (int k = 0; k < 5; k++)
         chk("bp_order", (k < pop_log.size()) ? pop_log[k] : 32'hDEAD_BEEF, exp_list[k]);

      // Memory not ready: request held stable.
      mem_ready_i = 1'b0;
      do_reset();
      for (int k = 0; k < 5; k++) begin
         step();
         chk("hold_valid", 32'(s_mem_valid), 32'd1);
         chk("hold_addr", s_addr, ResetPc);
      end
      mem_ready_i = 1'b1;
      repeat (10) step();

      // Redirect with two outstanding, no response in the redirect cycle.
      build_outstanding();
      redirect_i = 1'b1; redirect_pc_i = 32'h0000_0103;
      step();
      chk("redir_mem_valid", 32'(s_mem_valid), 32'd0);
      redirect_i = 1'b0;
      pop_log.delete();
      step();
      chk("redir_count", 32'(s_count), 32'd0);
      resp_hold = 1'b0;
      wait_pops(1, 20);
      chk("redir_first_pc", (pop_log.size() > 0) ? pop_log[0] : 32'hDEAD_BEEF, 32'h100);

      // Redirect with a response landing in the same cycle.
      build_outstanding();
      redirect_i = 1'b1; redirect_pc_i = 32'h0000_0200; resp_hold = 1'b0;
      step();
      chk("redir_rsp_mem_valid", 32'(s_mem_valid), 32'd0);
      redirect_i = 1'b0;
      pop_log.delete();
      wait_pops(1, 20);
      chk("redir_rsp_first_pc", (pop_log.size() > 0) ? pop_log[0] : 32'hDEAD_BEEF, 32'h200);

      // Back-to-back redirects: only the last target counts.
      redirect_i = 1'b1; redirect_pc_i = 32'h0000_0300;
      step();
      redirect_pc_i = 32'h0000_0404;
      step();
      redirect_i = 1'b0;
      pop_log.delete();
      wait_pops(1, 20);
      chk("b2b_first_pc", (pop_log.size() > 0) ? pop_log[0] : 32'hDEAD_BEEF, 32'h404);

      // Fetch PC wraps modulo 2^32.
      redirect_i = 1'b1; redirect_pc_i = 32'hFFFF_FFF9;
      step();
      redirect_i = 1'b0;
      pop_log.delete();
      wait_pops(4, 30);
      exp_list[0] = 32'hFFFF_FFF8; exp_list[1] = 32'hFFFF_FFFC;
      exp_list[2] = 32'h0; exp_list[3] = 32'h4;
      for (int k = 0; k < 4; k++)
         chk("wrap_pc", (k < pop_log.size()) ? pop_log[k] : 32'hDEAD_BEEF, exp_list[k]);

      // Reset in the middle of traffic.
      repeat (5) step();
      chk("pre_rst_inst_valid", 32'(s_inst_valid), 32'd1);
      do_reset();
      repeat (10) step();
      chk("post_rst_first_pc", (pop_log.size() > 0) ? pop_log[0] : 32'hDEAD_BEEF, ResetPc);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
